stream_arb2x1: RTL and testbench

Two-requester round-robin stream arbiter with a one-entry registered output. Channels 0 and 1 each present valid/ready/data beats. The arbiter picks one channel per cycle, drives the select of an internal `mux2x1` datapath, and captures the chosen beat into an output register for a single downstream consumer. It is the sequencing and sharing layer in front of the 2:1 multiplexer.

---
 rtl/stream_arb2x1.sv | 147 ++++++++++++++
 tb/tb_stream_arb2x1.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb2x1.sv
// -----------------------------------------------------------------------------
// stream_arb2x1 -- two-requester stream arbiter with a one-entry registered
// output stage. One channel is granted per cycle. The grant drives the select
// of a mux2x1 datapath, and the mux output is captured into the output
// register for a single downstream consumer.
//
// Build option:
//   ARB_RR_EN  defined   : round-robin on contention (a 'last' register is kept)
//              undefined : fixed priority, channel 0 wins on contention
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in0_valid  in   1      channel 0 beat present
//   in0_ready  out  1      channel 0 beat accepted (with in0_valid)
//   in0_data   in   WIDTH  channel 0 payload
//   in1_valid  in   1      channel 1 beat present
//   in1_ready  out  1      channel 1 beat accepted (with in1_valid)
//   in1_data   in   WIDTH  channel 1 payload
//   grant      out  2      one-hot current grant, 00 when nothing is valid
//   out_valid  out  1      output register holds a beat
//   out_ready  in   1      downstream accepts the output beat
//   out_data   out  WIDTH  registered payload
//   out_src    out  1      channel index that produced out_data
// -----------------------------------------------------------------------------

// mux2x1 -- plain 2:1 multiplexer, sel=0 picks a, sel=1 picks b.
//   sel in 1, a in WIDTH, b in WIDTH, y out WIDTH
module mux2x1 #(
   parameter int WIDTH = 8
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   assign y = sel ? b : a;
endmodule

module stream_arb2x1 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [WIDTH-1:0] in1_data,
   output logic [1:0]       grant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic             can_load;
   logic             take;
   logic [WIDTH-1:0] mux_y;

`ifdef ARB_RR_EN
   logic             last_q;   // index of the most recently accepted channel
`endif

   // Grant depends only on the valids (and 'last'), never on data.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      grant = 2'b00;
      case ({in1_valid, in0_valid})
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
`ifdef ARB_RR_EN
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
`else
         2'b11:   grant = 2'b01;
`endif
         default: grant = 2'b00;
      endcase
   end

   // The register can accept a new beat when empty, or when the current
   // beat leaves on this same edge.
   assign can_load  = (state_q == EMPTY) || out_ready;
   assign in0_ready = grant[0] & can_load;
   assign in1_ready = grant[1] & can_load;
   // A grant implies its valid is high, so any grant plus room is a transfer.
   assign take      = (grant != 2'b00) && can_load;

   mux2x1 #(.WIDTH(WIDTH)) u_mux (
      .sel (grant[1]),
      .a   (in0_data),
      .b   (in1_data),
      .y   (mux_y)
   );

   // Output register occupancy: a load wins over a drain, so a simultaneous
   // drain and load keeps the stage FULL at one beat per cycle.
   always_comb begin
      state_d = state_q;
      if (take) begin
         state_d = FULL;
      end else if (out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of statement order.
         state_q <= state_d;
      end
   end

   assign out_valid = (state_q == FULL);

   // NOTE: the payload register is reset as well, so out_data/out_src read
   // as zero immediately after reset instead of holding a discarded beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         out_src  <= 1'b0;
      end else if (take) begin
         out_data <= mux_y;
         out_src  <= grant[1];
      end
   end

`ifdef ARB_RR_EN
   // 'last' resets to 1 so channel 0 wins the first contended cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (take) begin
         last_q <= grant[1];
      end
   end
`endif

endmodule

// File: tb/tb_stream_arb2x1.sv
// -----------------------------------------------------------------------------
// tb_stream_arb2x1 -- self-checking bench for stream_arb2x1 (WIDTH=8).
// Grant/ready vectors from the reset state, directed multi-cycle sequences,
// an asynchronous reset during a stall, and a random soak against a small
// reference model with a beat scoreboard. Expectations follow ARB_RR_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stream_arb2x1;

   logic       clk = 1'b0;
   logic       rst;
   logic       in0_valid, in1_valid, out_ready;
   logic [7:0] in0_data, in1_data;
   logic       in0_ready, in1_ready, out_valid, out_src;
   logic [1:0] grant;
   logic [7:0] out_data;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       v0, v1, ordy;
      logic [1:0] g;
      logic       r0, r1;
   } vec_t;

   typedef struct packed {
      logic       src;
      logic [7:0] data;
   } beat_t;

   beat_t exp_q[$];

   always #5 clk = ~clk;

   stream_arb2x1 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_data  (in0_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .grant     (grant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 ns after the rising edge, well away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] model_grant(input logic v0, input logic v1, input logic last);
      logic [1:0] g;
      g = 2'b00;
      if (v0 && !v1) g = 2'b01;
      else if (v1 && !v0) g = 2'b10;
      else if (v0 && v1) begin
`ifdef ARB_RR_EN
         g = last ? 2'b01 : 2'b10;
`else
         g = 2'b01;
`endif
      end
      return g;
   endfunction

   initial begin
      vec_t       vecs[6];
      beat_t      b;
      logic       m_full, m_last, can, drain, xfer, exp_src;
      logic [1:0] eg;
      int         sent0, sent1, drained, cyc;

      // Vectors applied from the reset state (EMPTY, last=1), no clock edges.
      vecs[0] = '{v0:0, v1:0, ordy:0, g:2'b00, r0:0, r1:0};
      vecs[1] = '{v0:1, v1:0, ordy:0, g:2'b01, r0:1, r1:0};
      vecs[2] = '{v0:0, v1:1, ordy:0, g:2'b10, r0:0, r1:1};
      vecs[3] = '{v0:1, v1:1, ordy:0, g:2'b01, r0:1, r1:0};
      vecs[4] = '{v0:1, v1:1, ordy:1, g:2'b01, r0:1, r1:0};
      vecs[5] = '{v0:0, v1:1, ordy:1, g:2'b10, r0:0, r1:1};

      rst = 1'b1; in0_valid = 0; in1_valid = 0; out_ready = 0;
      in0_data = 8'h00; in1_data = 8'h00;
      #2;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_data",  out_data,  8'h00);
      check("reset_out_src",   out_src,   1'b0);
      check("reset_grant",     grant,     2'b00);
      tick(); tick();
      rst = 1'b0;

      // Vectors are held while clk is high and removed before the next edge.
      for (int i = 0; i < 6; i++) begin
         in0_valid = vecs[i].v0; in1_valid = vecs[i].v1; out_ready = vecs[i].ordy;
         #1;
         check($sformatf("vec%0d_grant", i), grant, vecs[i].g);
         check($sformatf("vec%0d_ready", i), {in1_ready, in0_ready}, {vecs[i].r1, vecs[i].r0});
      end
      in0_valid = 0; in1_valid = 0; out_ready = 0;
      tick();
      check("idle_out_valid", out_valid, 1'b0);

      // Single channel 1 beat.
      in1_valid = 1; in1_data = 8'hA5; out_ready = 1;
      #1;
      check("single_grant", grant, 2'b10);
      check("single_in1_ready", in1_ready, 1'b1);
      tick();
      in1_valid = 0;
      #1;
      check("single_out_data",  out_data,  8'hA5);
      check("single_out_src",   out_src,   1'b1);
      check("single_out_valid", out_valid, 1'b1);
      // Drain with nothing pending.
      check("drain_grant", grant, 2'b00);
      tick();
      check("drain_out_valid", out_valid, 1'b0);
      check("drain_grant_after", grant, 2'b00);

      // Continuous contention with out_ready=1.
      in0_valid = 1; in0_data = 8'h11; in1_valid = 1; in1_data = 8'h22; out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
`ifdef ARB_RR_EN
         exp_src = (i % 2 == 1);
`else
         exp_src = 1'b0;
`endif
         check($sformatf("contend%0d_src", i),  out_src,  exp_src);
         check($sformatf("contend%0d_data", i), out_data, exp_src ? 8'h22 : 8'h11);
         check($sformatf("contend%0d_valid", i), out_valid, 1'b1);
      end

      // Backpressure: load 33, stall 3 cycles with 44 pending, then release.
      in1_valid = 0; in0_data = 8'h33;
      tick();
      check("bp_load_data", out_data, 8'h33);
      in0_data = 8'h44; out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp%0d_in0_ready", i), in0_ready, 1'b0);
         check($sformatf("bp%0d_in1_ready", i), in1_ready, 1'b0);
         check($sformatf("bp%0d_out_data", i),  out_data,  8'h33);
         check($sformatf("bp%0d_out_valid", i), out_valid, 1'b1);
         tick();
      end
      out_ready = 1;
      #1;
      check("bp_release_in0_ready", in0_ready, 1'b1);
      tick();
      check("bp_next_data",  out_data,  8'h44);
      check("bp_next_src",   out_src,   1'b0);
      check("bp_next_valid", out_valid, 1'b1);
      in0_valid = 0; out_ready = 0;
      tick();
      check("stall_hold_valid", out_valid, 1'b1);

      // Asynchronous reset mid-stall, away from the clock edge.
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_out_data",  out_data,  8'h00);
      check("async_rst_out_src",   out_src,   1'b0);
      in0_valid = 1; in1_valid = 1;
      #1;
      // Last accepted beat was channel 0; reset returns priority to channel 0.
      check("async_rst_contend_grant", grant, 2'b01);
      in0_valid = 0; in1_valid = 0;
      tick();
      rst = 1'b0;
      tick();

      // Random soak against the model.
      m_full = 0; m_last = 1;
      sent0 = 0; sent1 = 0; drained = 0; cyc = 0;
      while ((sent0 < 200 || sent1 < 200 || m_full) && cyc < 6000) begin
         if (!in0_valid && sent0 < 200 && $urandom_range(0, 3) != 0) begin
            in0_valid = 1; in0_data = 8'($urandom);
         end
         if (!in1_valid && sent1 < 200 && $urandom_range(0, 3) != 0) begin
            in1_valid = 1; in1_data = 8'($urandom);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         can = !m_full || out_ready;
         eg  = model_grant(in0_valid, in1_valid, m_last);
         check("soak_grant", grant, eg);
         check("soak_ready", {in1_ready, in0_ready}, eg & {2{can}});
         check("soak_out_valid", out_valid, m_full);
         drain = m_full && out_ready;
         xfer  = (eg != 2'b00) && can;
         if (drain) begin
            b = exp_q.pop_front();
            check("soak_out_src",  out_src,  b.src);
            check("soak_out_data", out_data, b.data);
            drained++;
         end
         if (xfer) begin
            b.src  = eg[1];
            b.data = eg[1] ? in1_data : in0_data;
            exp_q.push_back(b);
            m_full = 1;
            m_last = eg[1];
            if (eg[1]) sent1++; else sent0++;
         end else if (drain) begin
            m_full = 0;
         end
         tick();
         if (xfer) begin
            if (eg[1]) in1_valid = 0; else in0_valid = 0;
         end
         cyc++;
      end
      check("soak_finished_in_budget", cyc < 6000, 1'b1);
      check("soak_drained_count", drained, 400);
      check("soak_queue_empty", exp_q.size(), 0);
      in0_valid = 0; in1_valid = 0; out_ready = 0;
      #1;
      check("soak_final_out_valid", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
